// File: rtl/booth4_seq_mult_ctrl_if.sv
// booth4_seq_mult_ctrl_if: operand/product valid-ready bundle for the sequential Booth-4 multiplier
interface booth4_seq_mult_ctrl_if #(parameter int WIDTH = 16);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     P;
  modport master(output in_valid, A, B, out_ready, input in_ready, out_valid, P);
  modport slave(input in_valid, A, B, out_ready, output in_ready, out_valid, P);
endinterface

// File: rtl/booth4_seq_mult_ctrl.sv
// booth4_seq_mult_ctrl: sequential radix-4 Booth multiplier, one group per clock.
// Define BOOTH4_EARLY_TERM_EN to finish as soon as the remaining multiplier groups all decode to zero.
module booth4_seq_mult_ctrl #(
  parameter int WIDTH = 16,
  localparam int STEPS = WIDTH / 2,
  localparam int SW = $clog2(STEPS)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  booth4_seq_mult_ctrl_if.slave bus,
  output logic                 busy,
  output logic [SW-1:0]        step_cnt
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, p_q, p_d, pp_sh, acc_sum;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [2:0]           code;
  logic [WIDTH+1:0]     a1, a2, pp;
  logic                 fin;
  // Group i sees {B[2i+1],B[2i],B[2i-1]} with a zero appended below bit 0.
  always_comb begin
    code = 3'({b_q, 1'b0} >> {cnt_q, 1'b0});
    a1 = {{2{a_q[WIDTH-1]}}, a_q};
    a2 = {a_q[WIDTH-1], a_q, 1'b0};
    pp = (code == 3'b000 || code == 3'b111) ? '0 :
         code == 3'b011 ? a2 :
         code == 3'b100 ? -a2 :
         code[2] ? -a1 : a1;
    pp_sh = {{(WIDTH-2){pp[WIDTH+1]}}, pp} << {cnt_q, 1'b0};
    acc_sum = acc_q + pp_sh;
  end
`ifdef BOOTH4_EARLY_TERM_EN
  logic signed [WIDTH-1:0] hi;
  always_comb begin
    hi = $signed(b_q) >>> {cnt_q, 1'b1};
    fin = (cnt_q == SW'(STEPS-1)) || (hi == '0) || (&hi);
  end
`else
  assign fin = cnt_q == SW'(STEPS-1);
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    p_d = p_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = CALC;
        a_d = bus.A;
        b_d = bus.B;
        acc_d = '0;
        cnt_d = '0;
      end
      CALC: begin
        acc_d = acc_sum;
        if (fin) begin
          state_d = DONE;
          p_d = acc_sum;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.P = p_q;
  assign busy = state_q != IDLE;
  assign step_cnt = cnt_q;
endmodule

// File: tb/tb_booth4_seq_mult_ctrl.sv
// tb_booth4_seq_mult_ctrl: scoreboard bench for booth4_seq_mult_ctrl (honours BOOTH4_EARLY_TERM_EN)
module tb_booth4_seq_mult_ctrl;
  logic sys_clk = 0, sys_rst = 1, rand_or = 0;
  logic busy;
  logic [2:0] step_cnt;
  int checks = 0, errors = 0, n_in = 0, n_out = 0;
  logic [31:0] sb[$];
  booth4_seq_mult_ctrl_if #(.WIDTH(16)) bus();
  booth4_seq_mult_ctrl #(.WIDTH(16)) dut(.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus), .busy(busy), .step_cnt(step_cnt));
  always #5 sys_clk = ~sys_clk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] prod(logic [15:0] a, logic [15:0] b);
    logic signed [31:0] sa, sb_;
    sa = {{16{a[15]}}, a};
    sb_ = {{16{b[15]}}, b};
    return sa * sb_;
  endfunction
  // Edges from acceptance to out_valid: groups whose upper multiplier bits are uniform end early.
  function automatic int exp_lat(logic [15:0] b);
`ifdef BOOTH4_EARLY_TERM_EN
    for (int i = 0; i < 8; i++) begin
      logic u;
      u = 1;
      for (int j = 2*i+1; j < 16; j++) if (b[j] != b[15]) u = 0;
      if (u) return i + 1;
    end
`endif
    return 8;
  endfunction
  always @(negedge sys_clk) begin
    if (sys_rst) sb.delete();
    else begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(prod(bus.A, bus.B));
        n_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 1);
        else check("P", bus.P, sb.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rand_or) bus.out_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic run_op(logic [15:0] a, logic [15:0] b);
    int n;
    check("in_ready_idle", bus.in_ready, 1);
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1;
    bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    check("busy_calc", busy, 1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", n, exp_lat(b));
`ifdef BOOTH4_EARLY_TERM_EN
    if (b == 16'h0003) check("step_cnt_et", step_cnt, 1);
`endif
    tick();
    check("out_valid_drop", bus.out_valid, 0);
  endtask
  initial begin
    int n;
    logic acc;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.A = 0;
    bus.B = 0;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_P", bus.P, 0);
    check("rst_step_cnt", step_cnt, 0);
    sys_rst = 0;
    tick();
    run_op(16'h5C0B, 16'h0003);
    run_op(16'h5C0B, 16'hFFFF);
    run_op(16'h8000, 16'h8000);
    run_op(16'h8000, 16'h7FFF);
    check("const_5c0b_3", prod(16'h5C0B, 16'h0003), 32'h00011421);
    // Backpressure: product must sit untouched while the consumer stalls.
    bus.out_ready = 0;
    bus.A = 16'h1234;
    bus.B = 16'h4321;
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_latency", n, exp_lat(16'h4321));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_P", bus.P, prod(16'h1234, 16'h4321));
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    // Reset in the middle of a calculation aborts without emitting.
    bus.A = 16'h1111;
    bus.B = 16'h2222;
    bus.in_valid = 1;
    bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    n = 0;
    while (step_cnt != 3 && n < 20) begin
      tick();
      n++;
    end
    check("reach_step3", step_cnt, 3);
    sys_rst = 1;
    tick();
    sys_rst = 0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_P", bus.P, 0);
    check("abort_busy", busy, 0);
    n_in = 0;
    n_out = 0;
    run_op(16'h0007, 16'h0006);
    check("P_after_abort", bus.P, 32'h0000002A);
    rand_or = 1;
    for (int k = 0; k < 1000; k++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      bus.in_valid = 1;
      acc = 0;
      n = 0;
      while (!acc && n < 200) begin
        acc = bus.in_ready;
        tick();
        n++;
      end
      bus.in_valid = 0;
      if (!acc) check("accept_timeout", n, 0);
    end
    rand_or = 0;
    bus.out_ready = 1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("sb_drained", 64'(sb.size()), 0);
    check("in_out_count", n_out, n_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
